// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register index/word widths, named registers and
// a one-hot register decode used by the writeback pending mask.
// Register indices are MSB-first ([0:N-1]) to match cpu_registerfile.
package cpu_pkg;

  localparam int unsigned CPU_REG_IDX_W = 4;
  localparam int unsigned CPU_NUM_REGS  = 16;
  localparam int unsigned CPU_REG_FP    = 0;
  localparam int unsigned CPU_REG_SP    = 1;
  localparam int unsigned CPU_WORD_W    = 32;

  typedef logic [CPU_REG_IDX_W-1:0] reg_idx_t;
  typedef logic [CPU_WORD_W-1:0]    word_t;

  // Bit r of the result (MSB-first numbering) is set for register r.
  function automatic logic [0:CPU_NUM_REGS-1] reg_onehot(input reg_idx_t idx);
    logic [0:CPU_NUM_REGS-1] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cpu_wbq_fifo.sv
// Load-result FIFO for the writeback queue.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   push, push_index/value      write one entry (ignored while full)
//   pop, head_index/value       remove the head entry (ignored while empty)
//   count, full, empty          occupancy
//   rd_ptr                      head slot, for age-ordered searches
//   ent_index, ent_value        every storage slot, raw
//   ent_valid                   per-slot occupancy
module cpu_wbq_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  reg_idx_t                           push_index,
  input  word_t                              push_value,
  input  logic                               pop,
  output reg_idx_t                           head_index,
  output word_t                              head_value,
  output logic [CNT_W-1:0]                   count,
  output logic                               full,
  output logic                               empty,
  output logic [PTR_W-1:0]                   rd_ptr,
  output logic [DEPTH-1:0][CPU_REG_IDX_W-1:0] ent_index,
  output logic [DEPTH-1:0][CPU_WORD_W-1:0]    ent_value,
  output logic [DEPTH-1:0]                   ent_valid
);

  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: every consumer gates slots with ent_valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      ent_index[wr_q] <= push_index;
      ent_value[wr_q] <= push_value;
    end
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    logic [PTR_W-1:0] off;
    ent_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PTR_W'(i) - rd_q;
      ent_valid[i] = (CNT_W'(off) < count_q);
    end
  end

  assign head_index = ent_index[rd_q];
  assign head_value = ent_value[rd_q];
  assign count      = count_q;
  assign rd_ptr     = rd_q;

endmodule

// File: rtl/cpu_writeback_queue.sv
// Writeback arbiter for the moxie register file: ALU results take the single
// write port immediately; load results queue in a FIFO and drain on idle
// ALU cycles. pending_o flags registers with queued or in-flight writes.
// Optional macro CPU_WBQ_FORWARD_EN enables a youngest-match forwarding lookup.
// Ports:
//   clk_i, rst_i                          clock, asynchronous active-high reset
//   alu_we_i, alu_index_i, alu_value_i    ALU result (always accepted)
//   alu_hold_o                            FIFO full, ALU must stay idle
//   ld_valid_i/ld_ready_o, ld_index_i/ld_value_i  load result handshake
//   rf_we_o, rf_index_o, rf_value_o       registered register-file write port
//   pending_o                             per-register pending mask
//   fwd_index_i, fwd_hit_o, fwd_value_o   forwarding lookup
module cpu_writeback_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     alu_we_i,
  input  logic [0:CPU_REG_IDX_W-1] alu_index_i,
  input  logic [CPU_WORD_W-1:0]    alu_value_i,
  output logic                     alu_hold_o,
  input  logic                     ld_valid_i,
  output logic                     ld_ready_o,
  input  logic [0:CPU_REG_IDX_W-1] ld_index_i,
  input  logic [CPU_WORD_W-1:0]    ld_value_i,
  output logic                     rf_we_o,
  output logic [0:CPU_REG_IDX_W-1] rf_index_o,
  output logic [CPU_WORD_W-1:0]    rf_value_o,
  output logic [0:CPU_NUM_REGS-1]  pending_o,
  input  logic [0:CPU_REG_IDX_W-1] fwd_index_i,
  output logic                     fwd_hit_o,
  output logic [CPU_WORD_W-1:0]    fwd_value_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                               push, pop, full, empty;
  reg_idx_t                           head_index;
  word_t                              head_value;
  logic [CNT_W-1:0]                   count;
  logic [PTR_W-1:0]                   rd_ptr;
  logic [DEPTH-1:0][CPU_REG_IDX_W-1:0] ent_index;
  logic [DEPTH-1:0][CPU_WORD_W-1:0]    ent_value;
  logic [DEPTH-1:0]                   ent_valid;

  logic     rf_we_q;
  reg_idx_t rf_index_q;
  word_t    rf_value_q;

  // No pass-through while full, even when a pop frees a slot this cycle.
  assign ld_ready_o = ~rst_i & ~full;
  assign alu_hold_o = full;
  assign push       = ld_valid_i & ld_ready_o;
  assign pop        = ~alu_we_i & ~empty;

  cpu_wbq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (push),
    .push_index (ld_index_i),
    .push_value (ld_value_i),
    .pop        (pop),
    .head_index (head_index),
    .head_value (head_value),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .rd_ptr     (rd_ptr),
    .ent_index  (ent_index),
    .ent_value  (ent_value),
    .ent_valid  (ent_valid)
  );

  // ALU wins the port; the FIFO head only drains on ALU-idle cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_we_q    <= 1'b0;
      rf_index_q <= '0;
      rf_value_q <= '0;
    end else if (alu_we_i) begin
      rf_we_q    <= 1'b1;
      rf_index_q <= alu_index_i;
      rf_value_q <= alu_value_i;
    end else if (pop) begin
      rf_we_q    <= 1'b1;
      rf_index_q <= head_index;
      rf_value_q <= head_value;
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_index_o = rf_index_q;
  assign rf_value_o = rf_value_q;

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pending_o = pending_o | reg_onehot(ent_index[i]);
    end
    if (rf_we_q) pending_o = pending_o | reg_onehot(rf_index_q);
  end

`ifdef CPU_WBQ_FORWARD_EN
  // Walk head to tail so younger matches overwrite older ones; the rf stage
  // is youngest of all and is applied last.
  always_comb begin
    logic [PTR_W-1:0] slot;
    fwd_hit_o   = 1'b0;
    fwd_value_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (ent_index[slot] == fwd_index_i)) begin
        fwd_hit_o   = 1'b1;
        fwd_value_o = ent_value[slot];
      end
    end
    if (rf_we_q && (rf_index_q == fwd_index_i)) begin
      fwd_hit_o   = 1'b1;
      fwd_value_o = rf_value_q;
    end
  end
`else
  assign fwd_hit_o   = 1'b0;
  assign fwd_value_o = '0;
  logic unused_fwd;
  assign unused_fwd = ^{fwd_index_i, ent_value, rd_ptr, count};
`endif

`ifndef SYNTHESIS
  // Upstream must not issue ALU writes while the FIFO is full.
  alu_hold_protocol : assert property (
    @(posedge clk_i) disable iff (rst_i) !(alu_we_i && alu_hold_o)
  ) else $error("cpu_writeback_queue: alu_we_i asserted while alu_hold_o high");
`endif

endmodule

// File: tb/tb_cpu_writeback_queue.sv
module tb_cpu_writeback_queue;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        alu_we_i;
  logic [0:3]  alu_index_i;
  logic [31:0] alu_value_i;
  logic        alu_hold_o;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [0:3]  ld_index_i;
  logic [31:0] ld_value_i;
  logic        rf_we_o;
  logic [0:3]  rf_index_o;
  logic [31:0] rf_value_o;
  logic [0:15] pending_o;
  logic [0:3]  fwd_index_i;
  logic        fwd_hit_o;
  logic [31:0] fwd_value_o;

  int ntests = 0;
  int nfail  = 0;

  cpu_writeback_queue #(
    .DEPTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .alu_we_i    (alu_we_i),
    .alu_index_i (alu_index_i),
    .alu_value_i (alu_value_i),
    .alu_hold_o  (alu_hold_o),
    .ld_valid_i  (ld_valid_i),
    .ld_ready_o  (ld_ready_o),
    .ld_index_i  (ld_index_i),
    .ld_value_i  (ld_value_i),
    .rf_we_o     (rf_we_o),
    .rf_index_o  (rf_index_o),
    .rf_value_o  (rf_value_o),
    .pending_o   (pending_o),
    .fwd_index_i (fwd_index_i),
    .fwd_hit_o   (fwd_hit_o),
    .fwd_value_o (fwd_value_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        alu_we;
    logic [3:0]  alu_idx;
    logic [31:0] alu_val;
    logic        ld_v;
    logic [3:0]  ld_idx;
    logic [31:0] ld_val;
    logic        e_we;
    logic [3:0]  e_idx;
    logic [31:0] e_val;
    logic [15:0] e_pend;
    logic        e_ready;
    logic        e_hold;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic aw, input logic [3:0] ai, input logic [31:0] av,
                       input logic lv, input logic [3:0] li, input logic [31:0] lval);
    alu_we_i    = aw;
    alu_index_i = ai;
    alu_value_i = av;
    ld_valid_i  = lv;
    ld_index_i  = li;
    ld_value_i  = lval;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [35:0] model_q [$];
  logic [35:0] ent;
  int          mcount;
  logic        exp_ready;

  initial begin
    // {we, idx, value, pending, ready, hold} expected after each edge
    vecs[0]  = '{1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0,
                 1'b1, 4'd3, 32'hDEADBEEF, 16'h1000, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
                 1'b0, 4'd3, 32'hDEADBEEF, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd2, 32'h12345678,
                 1'b0, 4'd3, 32'hDEADBEEF, 16'h2000, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
                 1'b1, 4'd2, 32'h12345678, 16'h2000, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
                 1'b0, 4'd2, 32'h12345678, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 32'h44,
                 1'b0, 4'd2, 32'h12345678, 16'h0800, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'd5, 32'h55, 1'b1, 4'd6, 32'h66,
                 1'b1, 4'd5, 32'h55, 16'h0E00, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'h77,
                 1'b1, 4'd4, 32'h44, 16'h0B00, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
                 1'b1, 4'd6, 32'h66, 16'h0300, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
                 1'b1, 4'd7, 32'h77, 16'h0100, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
                 1'b0, 4'd7, 32'h77, 16'h0000, 1'b1, 1'b0};

    rst_i       = 1'b1;
    fwd_index_i = 4'd0;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    #1;
    check("reset_outputs", {rf_we_o, rf_index_o, rf_value_o, pending_o, ld_ready_o, alu_hold_o},
          {1'b0, 4'd0, 32'h0, 16'h0, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("ready_after_reset", {63'd0, ld_ready_o}, 64'd1);

    // Table-driven single-cycle behaviour.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vecs[i].alu_we, vecs[i].alu_idx, vecs[i].alu_val,
            vecs[i].ld_v, vecs[i].ld_idx, vecs[i].ld_val);
      tick();
      check($sformatf("vec%0d", i),
            {rf_we_o, rf_index_o, rf_value_o, pending_o, ld_ready_o, alu_hold_o},
            {vecs[i].e_we, vecs[i].e_idx, vecs[i].e_val, vecs[i].e_pend,
             vecs[i].e_ready, vecs[i].e_hold});
    end

    // Fill with ALU busy, then alternate push/pop across the pointer wrap.
    model_q.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1, 4'd10, 32'hA0 + k, 1'b1, 4'(8 + k), 32'h100 + k);
      model_q.push_back({4'(8 + k), 32'h100 + k});
      tick();
      check($sformatf("fill_alu%0d", k), {31'd0, rf_we_o, rf_index_o, rf_value_o},
            {31'd0, 1'b1, 4'd10, 32'hA0 + k});
    end
    check("full_flags", {62'd0, ld_ready_o, alu_hold_o}, {62'd0, 1'b0, 1'b1});
    check("full_pending", {48'd0, pending_o}, 64'h00F0);
    mcount = 4;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1'b0, 4'd0, 32'h0, 1'b1, 4'(12 + (k % 4)), 32'h200 + k);
      #1;
      exp_ready = (mcount < 4);
      check($sformatf("alt_ready%0d", k), {63'd0, ld_ready_o}, {63'd0, exp_ready});
      ent = model_q.pop_front();
      if (exp_ready) model_q.push_back({4'(12 + (k % 4)), 32'h200 + k});
      mcount = model_q.size();
      tick();
      check($sformatf("alt_pop%0d", k), {27'd0, rf_we_o, rf_index_o, rf_value_o},
            {27'd0, 1'b1, ent});
    end
    for (int k = 0; k < 8 && model_q.size() > 0; k++) begin
      @(negedge clk);
      drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
      ent = model_q.pop_front();
      tick();
      check($sformatf("drain%0d", k), {27'd0, rf_we_o, rf_index_o, rf_value_o},
            {27'd0, 1'b1, ent});
    end
    tick();
    check("drained_idle", {47'd0, rf_we_o, pending_o}, 64'd0);

    // Forwarding lookup with two queued writes to register 9.
    @(negedge clk);
    drive(1'b1, 4'd0, 32'h0, 1'b1, 4'd9, 32'h1);
    tick();
    @(negedge clk);
    drive(1'b1, 4'd0, 32'h0, 1'b1, 4'd9, 32'h2);
    fwd_index_i = 4'd9;
    tick();
`ifdef CPU_WBQ_FORWARD_EN
    check("fwd_reg9", {31'd0, fwd_hit_o, fwd_value_o}, {31'd0, 1'b1, 32'h2});
`else
    check("fwd_disabled", {31'd0, fwd_hit_o, fwd_value_o}, 64'd0);
`endif
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    tick();
    check("fwd_drain0", {27'd0, rf_we_o, rf_index_o, rf_value_o}, {27'd0, 1'b1, 4'd9, 32'h1});
    tick();
    check("fwd_drain1", {27'd0, rf_we_o, rf_index_o, rf_value_o}, {27'd0, 1'b1, 4'd9, 32'h2});
    tick();

    // Reset mid-drain: queued loads to 5/6/7 must be discarded.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 4'd1, 32'hC0 + k, 1'b1, 4'(5 + k), 32'h500 + k);
      tick();
    end
    check("pre_reset_pending", {48'd0, pending_o}, 64'h4700);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    rst_i = 1'b1;
    #1;
    check("async_reset", {rf_we_o, rf_index_o, rf_value_o, pending_o, ld_ready_o, alu_hold_o},
          {1'b0, 4'd0, 32'h0, 16'h0, 1'b0, 1'b0});
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("ready_after_release", {63'd0, ld_ready_o}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("no_write%0d", k), {47'd0, rf_we_o, pending_o}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/cpu_writeback_queue.md
# cpu_writeback_queue

Write-side initiator for the moxie register file: merges single-cycle ALU results and variable-latency load results into the register file's single active write port. Loads are buffered in a small FIFO and drained when the ALU does not need the port. A per-register pending mask lets decode stall on registers with queued writes. Sits between the execute/memory stages and `cpu_registerfile`.

## Interface
- `DEPTH`, 4: load FIFO entries; power of two, ≥2.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `alu_we_i` in 1: ALU result valid this cycle; always accepted.
- `alu_index_i` in [0:3]: ALU destination register.
- `alu_value_i` in 32: ALU result.
- `alu_hold_o` out 1: FIFO full; upstream must keep `alu_we_i` low while high.
- `ld_valid_i` in 1: load result offered.
- `ld_ready_o` out 1: load accepted when `ld_valid_i & ld_ready_o`.
- `ld_index_i` in [0:3]: load destination register.
- `ld_value_i` in 32: load data.
- `rf_we_o` out 1: to register file `write_enable0_i`.
- `rf_index_o` out [0:3]: to `reg_write_index0_i`.
- `rf_value_o` out 32: to `value0_i`.
- `pending_o` out 16: bit r set while a write to register r is queued or in `rf_*`.
- `fwd_index_i` in [0:3]: forwarding lookup index (see Configuration).
- `fwd_hit_o` out 1: lookup matched a queued or in-flight write.
- `fwd_value_o` out 32: youngest matching value.

## Operation
- Each cycle, at most one write is selected into the registered `rf_*` outputs. ALU has priority; otherwise the FIFO head is popped.
- `rf_we_o` is low on any cycle with no selection. `rf_index_o`/`rf_value_o` hold their last value when `rf_we_o` is low.
- FIFO:
  - Push when `ld_valid_i & ld_ready_o`.
  - `ld_ready_o = !rst_i & (count != DEPTH)`. No pass-through while full, even if a pop occurs the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- A load accepted at cycle t is not eligible for pop until t+1 (no bypass into `rf_*`).
- `alu_hold_o = (count == DEPTH)`, combinational.
  - If `alu_we_i` is high while `alu_hold_o` is high, the ALU write still wins.
  - A simulation-only assertion (translate_off) reports this as a protocol error.
- `pending_o` is combinational:
  - OR of one-hot decodes of all valid FIFO entries' indices,
  - plus `rf_index_o` when `rf_we_o` is high.
- Decode must not issue an ALU op whose destination bit is set in `pending_o`. Under that rule, register-file write order equals program order.
- Index order: [0:3], bit 0 is MSB, matching the register file. Register 0 is fp and register 1 is sp, so pending bits 0 and 1 cover them.

## Timing
- ALU: `alu_we_i` at edge t → `rf_we_o`/`rf_index_o`/`rf_value_o` valid after edge t+1.
- Load, FIFO empty and no ALU traffic: accepted at edge t → popped at t+1 → `rf_we_o` after edge t+2.
- Drain rate: one entry per cycle without `alu_we_i`. Continuous ALU traffic starves loads until `alu_hold_o` forces a gap.
- Reset, any state, asynchronous:
  - count = 0, pointers = 0.
  - `rf_we_o`=0, `rf_index_o`=0, `rf_value_o`=0.
  - `pending_o`=0, `alu_hold_o`=0, `ld_ready_o`=0 while `rst_i` is high.
  - In-flight queued loads are discarded.
  - `ld_ready_o` goes to 1 the first cycle after reset deasserts.

## Configuration
- Macro `CPU_WBQ_FORWARD_EN`.
- Defined: `fwd_hit_o`/`fwd_value_o` are combinational.
  - Search order: `rf_*` stage (youngest) first, then FIFO entries from tail to head.
  - The first index match wins.
  - Decode may use the result instead of stalling on `pending_o`.
- Undefined: `fwd_hit_o`=0, `fwd_value_o`=0, `fwd_index_i` ignored, no compare logic synthesized.

## Structure
- Shared package `cpu_pkg` holds:
  - `CPU_REG_IDX_W` (4) and `CPU_NUM_REGS` (16),
  - `CPU_REG_FP` (0) and `CPU_REG_SP` (1),
  - `CPU_WORD_W` (32).
- Sub-module `cpu_wbq_fifo`: parameterized `DEPTH` FIFO.
  - Ports: push, pop, count, full, empty.
  - Exposes all entries and a valid vector for the pending/forward logic.

## Test plan
- Reset mid-drain: 3 loads queued, assert `rst_i` → all outputs 0 immediately; `ld_ready_o`=1 one cycle after release; registers 5/6/7 never written.
- ALU only: `alu_we_i`, index 3, 0xDEADBEEF at t → `rf_we_o`=1, index 3, 0xDEADBEEF after t+1; `pending_o`=0x1000 during that cycle.
- Load bypass latency: load index 2, 0x12345678 into empty FIFO with no ALU → `rf_we_o` two edges later; `pending_o` bit 2 set from accept until `rf_we_o` drops.
- Fill and wrap (`DEPTH`=4): 4 loads with ALU busy → `ld_ready_o`=0, `alu_hold_o`=1; then 10 alternating push/pop cycles → FIFO order preserved across pointer wrap, count correct.
- Simultaneous: ALU and FIFO head valid in the same cycle → ALU written first, head the next cycle; push+pop at count 2 → count stays 2.
- With `CPU_WBQ_FORWARD_EN`: two queued loads to register 9 (0x1, then 0x2) → `fwd_index_i`=9 gives hit, 0x2; without the macro → hit 0.
